wb_load_align: RTL and testbench
================================

Name: wb_load_align

Overview:
- Write-back stage for the MIPS pipeline; sits directly downstream of the data memory.
- Registers the MEM-stage result and load metadata, in step with the block RAM's one-cycle read latency.
- Selects, shifts and sign/zero-extends the raw memory word for lw/lh/lhu/lb/lbu, or passes the ALU result through, to drive the register-file write port.
- Holds the loaded word in a skid register so it survives WB stalls.

Parameters:
- DW, 32, data word width (fixed at 32; byte lanes assume 4).
- RW, 5, register address width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- m_valid  in  1  MEM stage holds a real instruction.
- m_opcode  in  6  MEM instruction opcode (lw=35, lb=32, lbu=36, lh=33, lhu=37; any other value is a non-load).
- m_byte  in  2  low address bits of the load (addr[1:0]).
- m_regwrite  in  1  instruction writes the register file.
- m_waddr  in  5  destination register.
- m_alu  in  32  ALU/forwarded result for non-loads.
- m_pc  in  32  instruction PC.
- ram_dout  in  32  raw data-memory output, valid the cycle after MEM.
- wb_stall  in  1  freeze WB (hold all state).
- flush  in  1  squash the MEM instruction entering WB.
- wb_valid  out  1  WB holds a real instruction.
- wb_we  out  1  register-file write enable.
- wb_waddr  out  5  register-file write address.
- wb_wdata  out  32  register-file write data.
- wb_pc  out  32  PC of the WB instruction.
- wb_adel  out  1  misaligned-load exception flag.

Behaviour:
- Stage registers: valid, opcode, byte, regwrite, waddr, alu, pc, plus hold_data[31:0] and hold_vld.
- Priority each edge: reset > flush > wb_stall > advance.
  - reset: all stage registers and hold state cleared to 0. Outputs read 0; wb_we=0.
  - flush (not stalled): valid←0, regwrite←0, hold_vld←0 (bubble).
  - flush while wb_stall=1: stall wins and the stage holds. The flush is honoured on the first unstalled edge by the upstream pipeline control, not here.
  - wb_stall=1: stage registers hold. If hold_vld=0, then hold_data←ram_dout and hold_vld←1 at that edge. If hold_vld=1, hold_data keeps its value.
  - advance (wb_stall=0): capture m_* into the stage registers; hold_vld←0.
- Load word source: hold_vld ? hold_data : ram_dout.
  - Latency: wb_wdata is valid in the cycle after the MEM→WB edge.
- Extension, by the byte value in the stage register:
  - lw: the full word.
  - lh/lhu: half = byte[1] ? word[31:16] : word[15:0]; sign- or zero-extend.
  - lb/lbu: lane = word[8*byte+7 : 8*byte]; sign- or zero-extend.
  - non-load: wb_wdata = alu.
- Alignment fault:
  - Condition: lw with byte≠0, or lh/lhu with byte[0]=1.
  - Response: wb_adel=valid, and wb_we forced 0.
- wb_we = valid & regwrite & ~adel & (waddr≠0). Writes to $0 are suppressed.
- wb_valid, wb_waddr and wb_pc are driven directly from the stage registers.
- Outputs are combinational from registered state plus ram_dout; there is no combinational path from m_* to the outputs.

Decomposition:
- Shared package holds:
  - opcode constants OP_LW/LB/LBU/LH/LHU;
  - a load-kind enum (LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU);
  - the decode function opcode→kind.
- One sub-module, load_ext: pure combinational word+byte+kind → extended data + misalign flag. It is reusable by a future MEM-stage forwarding path.

Test Plan:
- lb, byte=3, ram_dout=0x80FF1234 → wb_wdata=0xFFFFFF80, wb_we=1. Repeat as lbu → 0x00000080.
- lh, byte=2, ram_dout=0x9ABC5678 → 0xFFFF9ABC. lhu, byte=0 → 0x00005678.
- lw, ram_dout=0xDEADBEEF, then wb_stall=1 for 3 cycles while ram_dout changes to 0x11111111 → wb_wdata stays 0xDEADBEEF. After release, the next instruction's data appears.
- lw with byte=2 → wb_adel=1, wb_we=0. lh with byte=1 → same. lb with byte=1 → no fault.
- Non-load addu with alu=0x00000042, waddr=8 → wb_wdata=0x42, wb_we=1. Same with waddr=0 → wb_we=0.
- Flush with m_valid=1 → next cycle wb_valid=0, wb_we=0. Assert reset mid-stall → all outputs 0 and hold_vld cleared on the next edge.

Source files
------------

// File: rtl/wb_load_align_pkg.sv
// Shared load-kind decode and WB stage record for the MIPS write-back path.
// Pure declarations; no timing or flow control of its own.
package wb_load_align_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;

   typedef enum logic [2:0] {
      LD_NONE,
      LD_W,
      LD_H,
      LD_HU,
      LD_B,
      LD_BU
   } ld_kind_e;

   typedef struct packed {
      logic               valid;
      logic [5:0]         opcode;
      logic [1:0]         byte_off;
      logic               regwrite;
      logic [RADDR_W-1:0] waddr;
      logic [XLEN-1:0]    alu;
      logic [XLEN-1:0]    pc;
   } stage_t;

   function automatic ld_kind_e decode_load(input logic [5:0] opcode);
      case (opcode)
         OP_LW:   return LD_W;
         OP_LH:   return LD_H;
         OP_LHU:  return LD_HU;
         OP_LB:   return LD_B;
         OP_LBU:  return LD_BU;
         default: return LD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wb_load_align_if.sv
// MEM->WB bus: MEM-stage instruction fields, raw RAM data, stage control and the WB write port.
// Stall/flush are the only flow control; there is no handshake beyond them.
interface wb_load_align_if;
   import wb_load_align_pkg::*;

   logic               m_valid;
   logic [5:0]         m_opcode;
   logic [1:0]         m_byte;
   logic               m_regwrite;
   logic [RADDR_W-1:0] m_waddr;
   logic [XLEN-1:0]    m_alu;
   logic [XLEN-1:0]    m_pc;
   logic [XLEN-1:0]    ram_dout;
   logic               wb_stall;
   logic               flush;

   logic               wb_valid;
   logic               wb_we;
   logic [RADDR_W-1:0] wb_waddr;
   logic [XLEN-1:0]    wb_wdata;
   logic [XLEN-1:0]    wb_pc;
   logic               wb_adel;

   modport master (
      output m_valid, m_opcode, m_byte, m_regwrite, m_waddr, m_alu, m_pc,
      output ram_dout, wb_stall, flush,
      input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, wb_adel
   );

   modport slave (
      input  m_valid, m_opcode, m_byte, m_regwrite, m_waddr, m_alu, m_pc,
      input  ram_dout, wb_stall, flush,
      output wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, wb_adel
   );
endinterface

// File: rtl/wb_load_align_load_ext.sv
// Combinational lane select + sign/zero extension of a memory word, with misalignment flag.
// Zero latency; no flow control.
module wb_load_align_load_ext
   import wb_load_align_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_off,
   input  ld_kind_e    kind,
   output logic [31:0] data,
   output logic        misalign
);

   logic [15:0] half;
   logic [7:0]  lane;

   always_comb begin
      data     = word;
      misalign = 1'b0;
      half     = byte_off[1] ? word[31:16] : word[15:0];
      lane     = word[{byte_off, 3'b000} +: 8];
      case (kind)
         LD_W:  misalign = (byte_off != 2'b00);
         LD_H: begin
            data     = {{16{half[15]}}, half};
            misalign = byte_off[0];
         end
         LD_HU: begin
            data     = {16'h0000, half};
            misalign = byte_off[0];
         end
         LD_B:  data = {{24{lane[7]}}, lane};
         LD_BU: data = {24'h000000, lane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_load_align.sv
// MIPS write-back stage: registers MEM results, aligns/extends loads, drives the register-file port.
// Outputs valid the cycle after the MEM->WB edge; wb_stall freezes the stage and skids the RAM word.
module wb_load_align
   import wb_load_align_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
)(
   input  logic               clk,
   input  logic               reset,
   wb_load_align_if.slave     bus
);

   localparam logic [RW-1:0] ZERO_REG = '0;

   stage_t          stage_q, stage_d;
   logic [DW-1:0]   hold_data_q, hold_data_d;
   logic            hold_vld_q, hold_vld_d;

   logic [DW-1:0]   load_word;
   logic [DW-1:0]   ext_data;
   logic            misalign;
   ld_kind_e        kind;

   // Stall outranks flush; the upstream control re-issues the flush once WB moves.
   always_comb begin
      stage_d     = stage_q;
      hold_data_d = hold_data_q;
      hold_vld_d  = hold_vld_q;
      if (bus.wb_stall) begin
         if (!hold_vld_q) begin
            hold_data_d = bus.ram_dout;
            hold_vld_d  = 1'b1;
         end
      end else if (bus.flush) begin
         stage_d.valid    = 1'b0;
         stage_d.regwrite = 1'b0;
         hold_vld_d       = 1'b0;
      end else begin
         stage_d.valid    = bus.m_valid;
         stage_d.opcode   = bus.m_opcode;
         stage_d.byte_off = bus.m_byte;
         stage_d.regwrite = bus.m_regwrite;
         stage_d.waddr    = bus.m_waddr;
         stage_d.alu      = bus.m_alu;
         stage_d.pc       = bus.m_pc;
         hold_vld_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q     <= '0;
         hold_data_q <= '0;
         hold_vld_q  <= 1'b0;
      end else begin
         stage_q     <= stage_d;
         hold_data_q <= hold_data_d;
         hold_vld_q  <= hold_vld_d;
      end
   end

   assign kind      = decode_load(stage_q.opcode);
   assign load_word = hold_vld_q ? hold_data_q : bus.ram_dout;

   wb_load_align_load_ext u_load_ext (
      .word     (load_word),
      .byte_off (stage_q.byte_off),
      .kind     (kind),
      .data     (ext_data),
      .misalign (misalign)
   );

   assign bus.wb_valid = stage_q.valid;
   assign bus.wb_waddr = stage_q.waddr;
   assign bus.wb_pc    = stage_q.pc;
   assign bus.wb_wdata = (kind == LD_NONE) ? stage_q.alu : ext_data;
   assign bus.wb_adel  = stage_q.valid & misalign;
   assign bus.wb_we    = stage_q.valid & stage_q.regwrite & ~misalign &
                         (stage_q.waddr != ZERO_REG);

endmodule

// File: tb/tb_wb_load_align.sv
// Directed + randomized check of wb_load_align against a behavioural WB-stage model.
module tb_wb_load_align;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   wb_load_align_if bus ();

   wb_load_align #(.DW(32), .RW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model of what WB holds: the instruction record plus the skidded memory word.
   logic        mv, mrw, mhv;
   logic [5:0]  mop;
   logic [1:0]  mb;
   logic [4:0]  mwa;
   logic [31:0] malu, mpc, mhd;

   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] b);
      if (op == 6'd35) return (b != 2'd0);
      if (op == 6'd33 || op == 6'd37) return (b % 2 == 1);
      return 1'b0;
   endfunction

   function automatic logic [31:0] expect_data(input logic [5:0] op, input logic [1:0] b,
                                               input logic [31:0] alu, input logic [31:0] word);
      logic [31:0] v;
      case (op)
         6'd35: return word;
         6'd33, 6'd37: begin
            v = (b >= 2) ? (word >> 16) : (word & 32'h0000FFFF);
            v = v & 32'h0000FFFF;
            if (op == 6'd33 && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
         end
         6'd32, 6'd36: begin
            v = (word >> (8 * b)) & 32'h000000FF;
            if (op == 6'd32 && v >= 32'h80) v = v + 32'hFFFFFF00;
            return v;
         end
         default: return alu;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         mv = 0; mrw = 0; mhv = 0; mop = 0; mb = 0; mwa = 0; malu = 0; mpc = 0; mhd = 0;
      end else if (bus.wb_stall) begin
         if (!mhv) begin
            mhd = bus.ram_dout;
            mhv = 1'b1;
         end
      end else if (bus.flush) begin
         mv = 0; mrw = 0; mhv = 0;
      end else begin
         mv = bus.m_valid; mop = bus.m_opcode; mb = bus.m_byte; mrw = bus.m_regwrite;
         mwa = bus.m_waddr; malu = bus.m_alu; mpc = bus.m_pc; mhv = 0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] word;
      logic        adel;
      word = mhv ? mhd : bus.ram_dout;
      adel = mv & is_misaligned(mop, mb);
      chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(mv));
      chk({tag, ".we"},    32'(bus.wb_we),    32'(mv & mrw & ~adel & (mwa != 0)));
      chk({tag, ".waddr"}, 32'(bus.wb_waddr), 32'(mwa));
      chk({tag, ".pc"},    bus.wb_pc,         mpc);
      chk({tag, ".adel"},  32'(bus.wb_adel),  32'(adel));
      chk({tag, ".wdata"}, bus.wb_wdata,      expect_data(mop, mb, malu, word));
   endtask

   // Clock edge, then present this cycle's RAM output and compare.
   task automatic step(input string tag, input logic [31:0] ram_now);
      model_edge();
      @(posedge clk);
      #1 bus.ram_dout = ram_now;
      #1 check_all(tag);
   endtask

   task automatic issue(input logic [5:0] op, input logic [1:0] b, input logic [4:0] wa,
                        input logic [31:0] alu);
      bus.m_valid    = 1'b1;
      bus.m_opcode   = op;
      bus.m_byte     = b;
      bus.m_regwrite = 1'b1;
      bus.m_waddr    = wa;
      bus.m_alu      = alu;
      bus.m_pc       = $urandom;
   endtask

   initial begin
      logic [5:0] ops [6];
      ops[0] = 6'd32; ops[1] = 6'd33; ops[2] = 6'd35; ops[3] = 6'd36; ops[4] = 6'd37; ops[5] = 6'd0;

      reset = 1'b1;
      bus.m_valid = 0; bus.m_opcode = 0; bus.m_byte = 0; bus.m_regwrite = 0;
      bus.m_waddr = 0; bus.m_alu = 0; bus.m_pc = 0; bus.ram_dout = 0;
      bus.wb_stall = 0; bus.flush = 0;
      mv = 0; mrw = 0; mhv = 0; mop = 0; mb = 0; mwa = 0; malu = 0; mpc = 0; mhd = 0;

      step("reset0", 32'h0);
      step("reset1", 32'h12345678);
      chk("reset_wdata", bus.wb_wdata, 32'h0);
      reset = 1'b0;

      issue(6'd32, 2'd3, 5'd5, 32'h55);
      step("lb", 32'h80FF1234);
      chk("lb_const", bus.wb_wdata, 32'hFFFFFF80);
      chk("lb_we", 32'(bus.wb_we), 32'd1);
      issue(6'd36, 2'd3, 5'd5, 32'h55);
      step("lbu", 32'h80FF1234);
      chk("lbu_const", bus.wb_wdata, 32'h00000080);
      issue(6'd33, 2'd2, 5'd6, 32'h0);
      step("lh", 32'h9ABC5678);
      chk("lh_const", bus.wb_wdata, 32'hFFFF9ABC);
      issue(6'd37, 2'd0, 5'd6, 32'h0);
      step("lhu", 32'h9ABC5678);
      chk("lhu_const", bus.wb_wdata, 32'h00005678);

      issue(6'd35, 2'd0, 5'd7, 32'h0);
      step("lw", 32'hDEADBEEF);
      bus.wb_stall = 1'b1;
      issue(6'd35, 2'd0, 5'd9, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step("lw_stall", 32'h11111111);
         chk("stall_hold_const", bus.wb_wdata, 32'hDEADBEEF);
      end
      bus.wb_stall = 1'b0;
      step("lw_release", 32'hCAFEF00D);
      chk("release_const", bus.wb_wdata, 32'hCAFEF00D);

      issue(6'd35, 2'd2, 5'd3, 32'h0);
      step("lw_mis", 32'h01020304);
      chk("lw_mis_adel", 32'(bus.wb_adel), 32'd1);
      chk("lw_mis_we", 32'(bus.wb_we), 32'd0);
      issue(6'd33, 2'd1, 5'd3, 32'h0);
      step("lh_mis", 32'h01020304);
      chk("lh_mis_adel", 32'(bus.wb_adel), 32'd1);
      issue(6'd32, 2'd1, 5'd3, 32'h0);
      step("lb_ok", 32'h01028304);
      chk("lb_ok_adel", 32'(bus.wb_adel), 32'd0);
      chk("lb_ok_data", bus.wb_wdata, 32'hFFFFFF83);

      issue(6'd0, 2'd0, 5'd8, 32'h42);
      step("addu", 32'hFFFFFFFF);
      chk("addu_data", bus.wb_wdata, 32'h42);
      chk("addu_we", 32'(bus.wb_we), 32'd1);
      issue(6'd0, 2'd0, 5'd0, 32'h42);
      step("addu_r0", 32'hFFFFFFFF);
      chk("addu_r0_we", 32'(bus.wb_we), 32'd0);

      issue(6'd35, 2'd0, 5'd4, 32'h0);
      bus.flush = 1'b1;
      step("flush", 32'h77777777);
      chk("flush_valid", 32'(bus.wb_valid), 32'd0);
      chk("flush_we", 32'(bus.wb_we), 32'd0);
      bus.flush = 1'b0;

      issue(6'd35, 2'd0, 5'd4, 32'h0);
      step("pre_rst", 32'hA5A5A5A5);
      bus.wb_stall = 1'b1;
      step("rst_stall", 32'hBBBBBBBB);
      reset = 1'b1;
      step("mid_rst", 32'hCCCCCCCC);
      chk("mid_rst_valid", 32'(bus.wb_valid), 32'd0);
      chk("mid_rst_wdata", bus.wb_wdata, 32'h0);
      chk("mid_rst_hold_vld", 32'(dut.hold_vld_q), 32'd0);
      reset = 1'b0;
      bus.wb_stall = 1'b0;

      for (int n = 0; n < 400; n++) begin
         issue(ops[$urandom_range(0, 5)], 2'($urandom), 5'($urandom), $urandom);
         bus.m_valid    = ($urandom_range(0, 7) != 0);
         bus.m_regwrite = ($urandom_range(0, 7) != 0);
         if (bus.m_opcode == 6'd0) bus.m_opcode = 6'($urandom);
         bus.wb_stall = ($urandom_range(0, 3) == 0);
         bus.flush    = ($urandom_range(0, 9) == 0);
         reset        = ($urandom_range(0, 49) == 0);
         step("rand", $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
